uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 124 ++++++++++++
 tb/tb_uart_tx_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Two-requester command arbiter feeding a UART byte transmitter.
// Each 16-bit command is sent high byte first, then an idle gap.
module uart_tx_arb #(
  parameter int IDLE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req0_cmd,
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [15:0] req1_cmd,
  input  logic        req1_vld,
  output logic        req1_rdy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        grant,
  output logic        busy,
  output logic [15:0] cmd_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO,
    GAP
  } state_t;

  localparam logic [3:0] GAP_LOAD =
    4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        grant_q, grant_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        pick1;
  logic        idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      hold_q  <= 16'h0000;
      cnt_q   <= 16'h0000;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Requester 1 wins when alone or when the pointer favours it.
  always_comb begin
    idle     = (state_q == IDLE);
    pick1    = req1_vld & (~req0_vld | ptr_q);
    req0_rdy = idle & ~rst & req0_vld & ~pick1;
    req1_rdy = idle & ~rst & pick1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (req0_rdy | req1_rdy) begin
          hold_d  = pick1 ? req1_cmd : req0_cmd;
          grant_d = pick1;
          ptr_d   = ~pick1;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_rdy) state_d = SEND_LO;
      end
      SEND_LO: begin
        if (tx_rdy) begin
          cnt_d = cnt_q + 16'd1;
          if (IDLE_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else gap_d = gap_q - 4'd1;
      end
    endcase
  end

  always_comb begin
    tx_vld  = 1'b0;
    tx_data = 8'h00;
    unique case (state_q)
      SEND_HI: begin
        tx_vld  = 1'b1;
        tx_data = hold_q[15:8];
      end
      SEND_LO: begin
        tx_vld  = 1'b1;
        tx_data = hold_q[7:0];
      end
      default: ;
    endcase
  end

  assign grant   = grant_q;
  assign busy    = ~idle;
  assign cmd_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random traffic
// checked against a byte-queue reference model.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req0_cmd, req1_cmd;
  logic        req0_vld, req1_vld;
  logic        tx_rdy;

  logic        rdy0, rdy1, tx_vld, grant, busy;
  logic [7:0]  tx_data;
  logic [15:0] cmd_cnt;

  logic        g_rdy0, g_rdy1, g_vld, g_grant, g_busy;
  logic [7:0]  g_data;
  logic [15:0] g_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit use0  = 1'b0;

  logic [7:0]  mq[$];
  int          mgl;
  logic        mptr, mgrant;
  logic [15:0] mcnt;

  always #5 clk = ~clk;

  uart_tx_arb #(.IDLE_GAP(2)) dut (
    .clk(clk), .rst(rst),
    .req0_cmd(req0_cmd), .req0_vld(req0_vld),
    .req0_rdy(rdy0),
    .req1_cmd(req1_cmd), .req1_vld(req1_vld),
    .req1_rdy(rdy1),
    .tx_data(tx_data), .tx_vld(tx_vld),
    .tx_rdy(tx_rdy), .grant(grant),
    .busy(busy), .cmd_cnt(cmd_cnt)
  );

  uart_tx_arb #(.IDLE_GAP(0)) g0 (
    .clk(clk), .rst(rst),
    .req0_cmd(req0_cmd), .req0_vld(req0_vld),
    .req0_rdy(g_rdy0),
    .req1_cmd(req1_cmd), .req1_vld(req1_vld),
    .req1_rdy(g_rdy1),
    .tx_data(g_data), .tx_vld(g_vld),
    .tx_rdy(tx_rdy), .grant(g_grant),
    .busy(g_busy), .cmd_cnt(g_cnt)
  );

  // Reference: a command becomes two queued bytes; the block is
  // idle only when no byte is pending and no gap cycles remain.
  task automatic model_step();
    logic w;
    logic [15:0] c;
    if (rst) begin
      mq.delete();
      mgl = 0; mptr = 0; mgrant = 0; mcnt = 0;
    end else if (mq.size() == 0 && mgl == 0) begin
      if (req0_vld || req1_vld) begin
        w = req1_vld && (!req0_vld || mptr);
        c = w ? req1_cmd : req0_cmd;
        mq.push_back(c[15:8]);
        mq.push_back(c[7:0]);
        mgrant = w;
        mptr   = !w;
      end
    end else if (mq.size() == 0) begin
      mgl--;
    end else if (tx_rdy) begin
      void'(mq.pop_front());
      if (mq.size() == 0) begin
        mcnt++;
        mgl = use0 ? 0 : 2;
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0_vld = 0; req1_vld = 0; tx_rdy = 0;
    neg(); adv();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req0_vld = 1; req1_vld = 1; tx_rdy = 1;
    req0_cmd = 16'h1234; req1_cmd = 16'h5678;
    neg(); adv(); neg();
    n_vec += 7;
    if (rdy0 !== 1'b0) begin n_err++; $display("FAIL rst_rdy0 got %b want 0", rdy0); end
    if (rdy1 !== 1'b0) begin n_err++; $display("FAIL rst_rdy1 got %b want 0", rdy1); end
    if (tx_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld got %b want 0", tx_vld); end
    if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_data got %h want 00", tx_data); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    if (grant !== 1'b0) begin n_err++; $display("FAIL rst_grant got %b want 0", grant); end
    if (cmd_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt got %h want 0000", cmd_cnt); end
    adv();
    rst = 0; req0_vld = 0; req1_vld = 0;
  endtask

  task automatic test_single();
    logic       ev[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] ed[6] = '{8'h00, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    logic       eb[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    use0 = 0; do_reset();
    req0_cmd = 16'hA55A; req0_vld = 1; tx_rdy = 1;
    neg();
    n_vec += 2;
    if (rdy0 !== 1'b1) begin n_err++; $display("FAIL single_rdy0 got %b want 1", rdy0); end
    if (rdy1 !== 1'b0) begin n_err++; $display("FAIL single_rdy1 got %b want 0", rdy1); end
    adv();
    req0_vld = 0; req0_cmd = 16'h0000;
    for (int k = 1; k < 6; k++) begin
      neg();
      n_vec += 3;
      if (tx_vld !== ev[k]) begin n_err++; $display("FAIL single_vld c%0d got %b want %b", k, tx_vld, ev[k]); end
      if (tx_data !== ed[k]) begin n_err++; $display("FAIL single_data c%0d got %h want %h", k, tx_data, ed[k]); end
      if (busy !== eb[k]) begin n_err++; $display("FAIL single_busy c%0d got %b want %b", k, busy, eb[k]); end
      adv();
    end
    neg();
    n_vec++;
    if (cmd_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt got %h want 0001", cmd_cnt); end
  endtask

  task automatic test_alternate();
    logic [7:0] eb[6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h11, 8'h11};
    logic       eg[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] bt[6];
    logic       gr[3];
    int nb = 0;
    use0 = 0; do_reset();
    req0_cmd = 16'h1111; req1_cmd = 16'h2222;
    req0_vld = 1; req1_vld = 1; tx_rdy = 1;
    for (int c = 0; c < 40 && nb < 6; c++) begin
      neg();
      if (tx_vld) begin
        if (nb % 2 == 0) gr[nb/2] = grant;
        bt[nb] = tx_data;
        nb++;
      end
      adv();
    end
    n_vec++;
    if (nb !== 6) begin
      n_err++; $display("FAIL alt_timeout got %0d bytes want 6", nb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (bt[i] !== eb[i]) begin n_err++; $display("FAIL alt_byte%0d got %h want %h", i, bt[i], eb[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (gr[i] !== eg[i]) begin n_err++; $display("FAIL alt_grant%0d got %b want %b", i, gr[i], eg[i]); end
      end
    end
    req0_vld = 0; req1_vld = 0;
  endtask

  task automatic test_backpressure();
    logic [15:0] c;
    logic [7:0]  got[$];
    use0 = 0; do_reset();
    c = 16'($urandom);
    req0_cmd = c; req0_vld = 1; tx_rdy = 0;
    neg(); adv();
    req0_vld = 0;
    for (int i = 0; i < 5; i++) begin
      neg();
      n_vec += 2;
      if (tx_vld !== 1'b1) begin n_err++; $display("FAIL bp_vld c%0d got %b want 1", i, tx_vld); end
      if (tx_data !== c[15:8]) begin n_err++; $display("FAIL bp_data c%0d got %h want %h", i, tx_data, c[15:8]); end
      adv();
    end
    tx_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      neg();
      if (tx_vld && tx_rdy) got.push_back(tx_data);
      adv();
    end
    n_vec++;
    if (got.size() !== 2) begin
      n_err++; $display("FAIL bp_count got %0d want 2", got.size());
    end else begin
      n_vec += 2;
      if (got[0] !== c[15:8]) begin n_err++; $display("FAIL bp_hi got %h want %h", got[0], c[15:8]); end
      if (got[1] !== c[7:0]) begin n_err++; $display("FAIL bp_lo got %h want %h", got[1], c[7:0]); end
    end
    neg();
    n_vec++;
    if (cmd_cnt !== 16'd1) begin n_err++; $display("FAIL bp_cnt got %h want 0001", cmd_cnt); end
  endtask

  task automatic test_rst_mid();
    logic [15:0] c;
    use0 = 0; do_reset();
    c = 16'($urandom);
    req0_cmd = c; req0_vld = 1; tx_rdy = 1;
    neg(); adv();
    req0_vld = 0;
    neg(); adv();
    rst = 1; req0_vld = 1; req1_vld = 1;
    neg();
    n_vec += 3;
    if (tx_data !== c[7:0]) begin n_err++; $display("FAIL rm_lo got %h want %h", tx_data, c[7:0]); end
    if (rdy0 !== 1'b0) begin n_err++; $display("FAIL rm_rdy0 got %b want 0", rdy0); end
    if (rdy1 !== 1'b0) begin n_err++; $display("FAIL rm_rdy1 got %b want 0", rdy1); end
    adv();
    rst = 0;
    neg();
    n_vec += 5;
    if (tx_vld !== 1'b0) begin n_err++; $display("FAIL rm_vld got %b want 0", tx_vld); end
    if (cmd_cnt !== 16'h0) begin n_err++; $display("FAIL rm_cnt got %h want 0000", cmd_cnt); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b want 0", busy); end
    if (rdy0 !== 1'b1) begin n_err++; $display("FAIL rm_ptr0 got %b want 1", rdy0); end
    if (rdy1 !== 1'b0) begin n_err++; $display("FAIL rm_ptr1 got %b want 0", rdy1); end
    adv();
    req0_vld = 0; req1_vld = 0;
    neg();
    n_vec += 2;
    if (tx_data !== c[15:8]) begin n_err++; $display("FAIL rm_next got %h want %h", tx_data, c[15:8]); end
    if (grant !== 1'b0) begin n_err++; $display("FAIL rm_grant got %b want 0", grant); end
    adv();
  endtask

  task automatic test_gap0();
    logic [15:0] c;
    use0 = 1; do_reset();
    c = 16'($urandom);
    req0_cmd = c; req0_vld = 1; tx_rdy = 1;
    neg();
    n_vec++;
    if (g_rdy0 !== 1'b1) begin n_err++; $display("FAIL g0_acc got %b want 1", g_rdy0); end
    adv();
    neg();
    n_vec += 2;
    if (g_data !== c[15:8]) begin n_err++; $display("FAIL g0_hi got %h want %h", g_data, c[15:8]); end
    if (g_rdy0 !== 1'b0) begin n_err++; $display("FAIL g0_rdy_hi got %b want 0", g_rdy0); end
    adv();
    neg();
    n_vec += 2;
    if (g_vld !== 1'b1) begin n_err++; $display("FAIL g0_vld_lo got %b want 1", g_vld); end
    if (g_data !== c[7:0]) begin n_err++; $display("FAIL g0_lo got %h want %h", g_data, c[7:0]); end
    adv();
    neg();
    n_vec += 3;
    if (g_rdy0 !== 1'b1) begin n_err++; $display("FAIL g0_reacc got %b want 1", g_rdy0); end
    if (g_busy !== 1'b0) begin n_err++; $display("FAIL g0_busy got %b want 0", g_busy); end
    if (g_cnt !== 16'd1) begin n_err++; $display("FAIL g0_cnt got %h want 0001", g_cnt); end
    adv();
    req0_vld = 0;
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    use0 = 1; do_reset();
    g0.cnt_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    req0_cmd = 16'($urandom); req0_vld = 1; tx_rdy = 1;
    for (int k = 0; k < 10; k++) begin
      neg();
      e = 16'(32'hFFFE + k / 3);
      n_vec++;
      if (g_cnt !== e) begin n_err++; $display("FAIL wrap_cnt c%0d got %h want %h", k, g_cnt, e); end
      if (k % 3 == 1) begin
        n_vec++;
        if (g_vld !== 1'b1) begin n_err++; $display("FAIL wrap_vld c%0d got %b want 1", k, g_vld); end
      end
      adv();
    end
    req0_vld = 0;
  endtask

  task automatic test_random(input bit sel, input int n);
    logic idle, w, e_r0, e_r1, e_v, e_b;
    logic [7:0] e_d;
    logic o_r0, o_r1, o_v, o_b, o_g;
    logic [7:0] o_d;
    logic [15:0] o_c;
    use0 = sel; do_reset();
    for (int i = 0; i < n; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      req0_vld = ($urandom_range(0, 2) != 0);
      req1_vld = ($urandom_range(0, 2) != 0);
      req0_cmd = 16'($urandom);
      req1_cmd = 16'($urandom);
      tx_rdy   = ($urandom_range(0, 9) < 7);
      neg();
      idle = (mq.size() == 0) && (mgl == 0);
      w    = req1_vld && (!req0_vld || mptr);
      e_r0 = !rst && idle && req0_vld && !w;
      e_r1 = !rst && idle && w;
      e_v  = (mq.size() != 0);
      e_d  = e_v ? mq[0] : 8'h00;
      e_b  = !idle;
      o_r0 = sel ? g_rdy0  : rdy0;
      o_r1 = sel ? g_rdy1  : rdy1;
      o_v  = sel ? g_vld   : tx_vld;
      o_d  = sel ? g_data  : tx_data;
      o_b  = sel ? g_busy  : busy;
      o_g  = sel ? g_grant : grant;
      o_c  = sel ? g_cnt   : cmd_cnt;
      n_vec += 7;
      if (o_r0 !== e_r0) begin n_err++; $display("FAIL rnd_rdy0 c%0d got %b want %b", i, o_r0, e_r0); end
      if (o_r1 !== e_r1) begin n_err++; $display("FAIL rnd_rdy1 c%0d got %b want %b", i, o_r1, e_r1); end
      if (o_v !== e_v) begin n_err++; $display("FAIL rnd_vld c%0d got %b want %b", i, o_v, e_v); end
      if (o_d !== e_d) begin n_err++; $display("FAIL rnd_data c%0d got %h want %h", i, o_d, e_d); end
      if (o_b !== e_b) begin n_err++; $display("FAIL rnd_busy c%0d got %b want %b", i, o_b, e_b); end
      if (o_g !== mgrant) begin n_err++; $display("FAIL rnd_grant c%0d got %b want %b", i, o_g, mgrant); end
      if (o_c !== mcnt) begin n_err++; $display("FAIL rnd_cnt c%0d got %h want %h", i, o_c, mcnt); end
      adv();
    end
    rst = 0; req0_vld = 0; req1_vld = 0;
  endtask

  initial begin
    rst = 1; req0_vld = 0; req1_vld = 0; tx_rdy = 0;
    req0_cmd = 16'h0; req1_cmd = 16'h0;
    mgl = 0; mptr = 0; mgrant = 0; mcnt = 0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_rst_mid();
    test_gap0();
    test_wrap();
    test_random(1'b0, 600);
    test_random(1'b1, 600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
